// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
// -----------------------------------------------------------------------------
// Shares one NoC injection channel between NumReq local requesters. Arbitration
// is round-robin and packet-locking: once a requester has presented a flit, it
// keeps the channel until the flit carrying req_last_i has been accepted. This
// means packets never interleave, and a stalled flit is never withdrawn.
//
// Optional feature: define NOC_INJECT_ARBITER_SPILL_EN to place a 2-entry
// spill register between the arbiter mux and the out_* ports. This adds one
// cycle of latency and breaks the out_ready_i -> req_ready_o path. Throughput
// stays at one flit per cycle.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_valid_i    per-requester flit valid
//   req_ready_o    per-requester flit accepted
//   req_data_i     per-requester payload, requester k at [k*DataWidth +: DataWidth]
//   req_last_i     per-requester last-flit-of-packet marker
//   out_valid_o    injection flit valid
//   out_ready_i    injection channel ready
//   out_data_o     injected payload
//   out_last_o     injected last marker
//   out_idx_o      index of the requester owning the current flit
//   busy_o         high while a packet is in progress (LOCKED)
//   pkt_cnt_o      completed-packet counter, wraps at 2^32
// -----------------------------------------------------------------------------
module noc_inject_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int IdxWidth  = $clog2(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic                          out_last_o,
    output logic [IdxWidth-1:0]           out_idx_o,
    output logic                          busy_o,
    output logic [31:0]                   pkt_cnt_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q;
    logic [IdxWidth-1:0]   rrPtr_q;
    logic [IdxWidth-1:0]   owner_q;
    logic [31:0]           pktCnt_q;

    logic                  found;
    logic [IdxWidth-1:0]   selIdle;
    logic [IdxWidth-1:0]   sel;
    logic                  grantEn;
    logic                  muxValid;
    logic [DataWidth-1:0]  muxData;
    logic                  muxLast;
    logic [IdxWidth-1:0]   muxIdx;
    logic                  inReady;
    logic                  fire;

    function automatic logic [IdxWidth-1:0] nextPtr(input logic [IdxWidth-1:0] p);
        return (int'(p) == NumReq - 1) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or after rrPtr_q, wrapping.
    always_comb begin
        found   = 1'b0;
        selIdle = '0;
        for (int i = 0; i < NumReq; i++) begin
            int j;
            j = int'(rrPtr_q) + i;
            if (j >= NumReq) j = j - NumReq;
            if (!found && req_valid_i[j]) begin
                found   = 1'b1;
                selIdle = IdxWidth'(j);
            end
        end
    end

    // While LOCKED only the owner is muxed. Its valid may drop (bubble), but
    // the grant and its ready bit stay on the owner. Everything is forced to
    // zero while rst_i is high so outputs clear immediately on reset.
    always_comb begin
        sel      = (state_q == LOCKED) ? owner_q : selIdle;
        grantEn  = ((state_q == LOCKED) || found) && !rst_i;
        muxValid = grantEn && req_valid_i[sel];
        muxData  = muxValid ? req_data_i[int'(sel)*DataWidth +: DataWidth] : '0;
        muxLast  = muxValid && req_last_i[sel];
        muxIdx   = grantEn ? sel : '0;
    end

    assign fire        = muxValid && inReady;
    assign req_ready_o = grantEn ? (NumReq'(inReady) << sel) : '0;
    assign busy_o      = (state_q == LOCKED);
    assign pkt_cnt_o   = pktCnt_q;

    // Arbitration state. Any presented flit that does not complete a packet
    // (stalled, or accepted without last) freezes the grant on that requester.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rrPtr_q  <= '0;
            owner_q  <= '0;
            pktCnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        if (fire && req_last_i[selIdle]) begin
                            rrPtr_q  <= nextPtr(selIdle);
                            pktCnt_q <= pktCnt_q + 32'd1;
                        end else begin
                            state_q <= LOCKED;
                            owner_q <= selIdle;
                        end
                    end
                end
                LOCKED: begin
                    if (fire && req_last_i[owner_q]) begin
                        state_q  <= IDLE;
                        rrPtr_q  <= nextPtr(owner_q);
                        pktCnt_q <= pktCnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef NOC_INJECT_ARBITER_SPILL_EN
    localparam int SlotWidth = IdxWidth + 1 + DataWidth;

    logic [SlotWidth-1:0] slot_q [2];
    logic                 wrPtr_q;
    logic                 rdPtr_q;
    logic [1:0]           fill_q;
    logic                 pop;

    // Input-side ready depends only on registered fill level, so there is
    // no combinational path from out_ready_i to req_ready_o.
    assign inReady = (fill_q != 2'd2) && !rst_i;
    assign pop     = (fill_q != 2'd0) && out_ready_i;

    // Two-slot ring buffer; index, last and data travel together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            fill_q    <= 2'd0;
        end else begin
            if (fire) begin
                slot_q[wrPtr_q] <= {muxIdx, muxLast, muxData};
                wrPtr_q         <= ~wrPtr_q;
            end
            if (pop) rdPtr_q <= ~rdPtr_q;
            fill_q <= fill_q + 2'(fire) - 2'(pop);
        end
    end

    assign out_valid_o                          = (fill_q != 2'd0);
    assign {out_idx_o, out_last_o, out_data_o}  = slot_q[rdPtr_q];
`else
    assign inReady     = out_ready_i && !rst_i;
    assign out_valid_o = muxValid;
    assign out_data_o  = muxData;
    assign out_last_o  = muxLast;
    assign out_idx_o   = muxIdx;
`endif

endmodule
